// File: rtl/spi_pkg.sv
// Shared types and frame constants for the arbitrated SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } spi_mst_state_t;

    localparam int unsigned SPI_FRAME_BITS    = 8;
    localparam int unsigned SPI_LEAD_PERIODS  = 1;
    localparam int unsigned SPI_TRAIL_PERIODS = 1;
    localparam int unsigned SPI_GAP_PERIODS   = 1;

    // Period counter must cover the longest of lead, data and trail phases.
    localparam int unsigned SPI_BIT_CNT_W = $clog2(SPI_FRAME_BITS);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    int unsigned cand;
    logic        found;

    // Scan requesters in modulo order starting at the pointer.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_master_arb.sv
// Round-robin arbitrated write-only SPI master (optional MISO capture via
// SPI_MASTER_MISO_EN). Frame: lead period, 8 data bits MSB first, trail period,
// then a gap with cs high. mosi changes on sclk rise, slave samples on fall.
module spi_master_arb
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic                      sclk,
    output logic                      mosi,
    output logic                      cs
`ifdef SPI_MASTER_MISO_EN
    ,
    input  logic                      miso,
    output logic [DATA_W-1:0]         rx_data
`endif
);

    localparam int unsigned IDX_W   = $clog2(NUM_REQ);
    localparam int unsigned GAP_CYC = 2 * CLK_DIV * SPI_GAP_PERIODS;
    localparam int unsigned CNT_W   = $clog2(GAP_CYC);
    localparam int unsigned BC_W    = SPI_BIT_CNT_W;

    spi_mst_state_t     state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [BC_W-1:0]    bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0]  sr, sr_d;
    logic [IDX_W-1:0]   owner, owner_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [NUM_REQ-1:0] gnt_d, done_d;
    logic               busy_d, sclk_d, mosi_d, cs_d;
`ifdef SPI_MASTER_MISO_EN
    logic [DATA_W-1:0]  rx_sr, rx_sr_d;
    logic [DATA_W-1:0]  rx_data_d;
`endif

    logic               arb_en;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               half_end;

    assign arb_en   = (state == IDLE);
    assign half_end = (cnt == CNT_W'(CLK_DIV - 1));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            owner   <= '0;
            ptr     <= '0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs      <= 1'b1;
`ifdef SPI_MASTER_MISO_EN
            rx_sr   <= '0;
            rx_data <= '0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_cnt_d;
            sr      <= sr_d;
            owner   <= owner_d;
            ptr     <= ptr_d;
            gnt     <= gnt_d;
            done    <= done_d;
            busy    <= busy_d;
            sclk    <= sclk_d;
            mosi    <= mosi_d;
            cs      <= cs_d;
`ifdef SPI_MASTER_MISO_EN
            rx_sr   <= rx_sr_d;
            rx_data <= rx_data_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_cnt_d = bit_cnt;
        sr_d      = sr;
        owner_d   = owner;
        ptr_d     = ptr;
        gnt_d     = '0;
        done_d    = '0;
        busy_d    = busy;
        sclk_d    = sclk;
        mosi_d    = mosi;
        cs_d      = cs;
`ifdef SPI_MASTER_MISO_EN
        rx_sr_d   = rx_sr;
        rx_data_d = rx_data;
`endif
        case (state)
            IDLE: begin
                if (|arb_gnt) begin
                    gnt_d     = arb_gnt;
                    sr_d      = tx_data[arb_idx*DATA_W +: DATA_W];
                    owner_d   = arb_idx;
                    ptr_d     = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    sclk_d    = 1'b0;
                    mosi_d    = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = LEAD;
                end
            end
            LEAD, SHIFT, TRAIL: begin
                if (!half_end) begin
                    cnt_d = cnt + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!sclk) begin
                        // Rising edge: present the next bit (zero outside SHIFT).
                        sclk_d = 1'b1;
                        if (state == SHIFT) begin
                            mosi_d = sr[DATA_W-1];
                            sr_d   = {sr[DATA_W-2:0], 1'b0};
                        end else begin
                            mosi_d = 1'b0;
                        end
                    end else begin
                        // Falling edge: close out the period.
                        sclk_d = 1'b0;
                        case (state)
                            LEAD: begin
                                if (bit_cnt == BC_W'(SPI_LEAD_PERIODS - 1)) begin
                                    bit_cnt_d = '0;
                                    state_d   = SHIFT;
                                end else begin
                                    bit_cnt_d = bit_cnt + BC_W'(1);
                                end
                            end
                            SHIFT: begin
`ifdef SPI_MASTER_MISO_EN
                                rx_sr_d = {rx_sr[DATA_W-2:0], miso};
`endif
                                if (bit_cnt == BC_W'(SPI_FRAME_BITS - 1)) begin
                                    bit_cnt_d = '0;
                                    state_d   = TRAIL;
                                end else begin
                                    bit_cnt_d = bit_cnt + BC_W'(1);
                                end
                            end
                            TRAIL: begin
                                if (bit_cnt == BC_W'(SPI_TRAIL_PERIODS - 1)) begin
                                    bit_cnt_d     = '0;
                                    done_d[owner] = 1'b1;
                                    cs_d          = 1'b1;
                                    state_d       = GAP;
`ifdef SPI_MASTER_MISO_EN
                                    rx_data_d     = rx_sr;
`endif
                                end else begin
                                    bit_cnt_d = bit_cnt + BC_W'(1);
                                end
                            end
                            default: begin
                                state_d = IDLE;
                            end
                        endcase
                    end
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: instance A uses CLK_DIV=2, instance B
// uses CLK_DIV=1. A falling-edge slave model per instance collects bytes.
module tb_spi_master_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int vecs = 0;
    int errs = 0;

    logic        rst_a, rst_b;
    logic [1:0]  req_a, req_b;
    logic [15:0] txd_a, txd_b;
    logic [1:0]  gnt_a, gnt_b, done_a, done_b;
    logic        busy_a, busy_b, sclk_a, sclk_b, mosi_a, mosi_b, cs_a, cs_b;
`ifdef SPI_MASTER_MISO_EN
    logic        miso_a = 1'b0;
    logic        miso_b = 1'b0;
    logic [7:0]  rx_a, rx_b;
    logic [7:0]  miso_pat = 8'h5A;
`endif

    spi_master_arb #(.NUM_REQ(2), .DATA_W(8), .CLK_DIV(2)) u_dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .req     (req_a),
        .tx_data (txd_a),
        .gnt     (gnt_a),
        .done    (done_a),
        .busy    (busy_a),
        .sclk    (sclk_a),
        .mosi    (mosi_a),
        .cs      (cs_a)
`ifdef SPI_MASTER_MISO_EN
        ,
        .miso    (miso_a),
        .rx_data (rx_a)
`endif
    );

    spi_master_arb #(.NUM_REQ(2), .DATA_W(8), .CLK_DIV(1)) u_dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .req     (req_b),
        .tx_data (txd_b),
        .gnt     (gnt_b),
        .done    (done_b),
        .busy    (busy_b),
        .sclk    (sclk_b),
        .mosi    (mosi_b),
        .cs      (cs_b)
`ifdef SPI_MASTER_MISO_EN
        ,
        .miso    (miso_b),
        .rx_data (rx_b)
`endif
    );

    // Slave model A: falling-edge capture while cs was low, first edge is the lead.
    logic       psclk_a = 1'b0, pcs_a = 1'b1;
    int         edges_a = 0, low_a = 0, high_a = 0;
    int         last_edges_a = 0, last_low_a = 0, last_high_a = 0;
    logic [7:0] shr_a = '0;
    logic [7:0] bytes_a[$];
    initial forever begin
        @(negedge clk);
        if (psclk_a && !sclk_a && !pcs_a) begin
            edges_a++;
            if (edges_a >= 2 && edges_a <= 9) begin
                shr_a = {shr_a[6:0], mosi_a};
                if (edges_a == 9) bytes_a.push_back(shr_a);
            end
`ifdef SPI_MASTER_MISO_EN
            if (edges_a >= 1 && edges_a <= 8) miso_a = miso_pat[8-edges_a];
`endif
        end
        if (!cs_a) begin
            if (pcs_a) last_high_a = high_a;
            high_a = 0;
            low_a++;
        end else begin
            if (!pcs_a) begin
                last_low_a   = low_a;
                last_edges_a = edges_a;
            end
            low_a   = 0;
            edges_a = 0;
            high_a++;
        end
        psclk_a = sclk_a;
        pcs_a   = cs_a;
    end

    // Slave model B: same framing rules for the CLK_DIV=1 instance.
    logic       psclk_b = 1'b0, pcs_b = 1'b1;
    int         edges_b = 0, low_b = 0, last_low_b = 0;
    logic [7:0] shr_b = '0;
    logic [7:0] bytes_b[$];
    initial forever begin
        @(negedge clk);
        if (psclk_b && !sclk_b && !pcs_b) begin
            edges_b++;
            if (edges_b >= 2 && edges_b <= 9) begin
                shr_b = {shr_b[6:0], mosi_b};
                if (edges_b == 9) bytes_b.push_back(shr_b);
            end
        end
        if (!cs_b) begin
            low_b++;
        end else begin
            if (!pcs_b) last_low_b = low_b;
            low_b   = 0;
            edges_b = 0;
        end
        psclk_b = sclk_b;
        pcs_b   = cs_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input bit sel, output logic [1:0] g, output int t);
        g = '0;
        t = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sel ? gnt_b : gnt_a) != 2'b00) begin
                g = sel ? gnt_b : gnt_a;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(input bit sel, output logic [1:0] d);
        d = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sel ? done_b : done_a) != 2'b00) begin
                d = sel ? done_b : done_a;
                break;
            end
        end
    endtask

    task automatic pop_byte(input bit sel, output logic [7:0] b);
        b = 8'hxx;
        if (sel) begin
            if (bytes_b.size() > 0) b = bytes_b.pop_front();
        end else begin
            if (bytes_a.size() > 0) b = bytes_a.pop_front();
        end
    endtask

    // One request-grant-done cycle on instance A, request dropped after grant.
    task automatic frame_a(input logic [1:0] r, input logic [15:0] d,
                           input logic [1:0] exp_g, input logic [7:0] exp_b, input string tag);
        logic [1:0] g, dn;
        logic [7:0] b;
        int         t;
        req_a = r;
        txd_a = d;
        wait_gnt(1'b0, g, t);
        check({tag, "_gnt"}, 32'(g), 32'(exp_g));
        req_a = 2'b00;
        wait_done(1'b0, dn);
        check({tag, "_done"}, 32'(dn), 32'(exp_g));
        @(negedge clk);
        pop_byte(1'b0, b);
        check({tag, "_byte"}, 32'(b), 32'(exp_b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g, dn;
        logic [7:0] b;
        int         t, tprev, cnt;
        logic [1:0] exp_seq [3];
        logic       prev;

        rst_a = 1'b1; req_a = '0; txd_a = '0;
        rst_b = 1'b1; req_b = '0; txd_b = '0;
        tprev = 0;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
        repeat (3) @(negedge clk);

        // Reset values on A: {cs,sclk,mosi,busy,gnt,done}.
        check("reset_a", 32'({cs_a, sclk_a, mosi_a, busy_a, gnt_a, done_a}), 32'h80);
`ifdef SPI_MASTER_MISO_EN
        check("reset_rx_a", 32'(rx_a), 32'h0);
`endif
        rst_a = 1'b0;

        // Single frame, A5 from requester 0.
        req_a = 2'b01;
        txd_a = 16'h00A5;
        wait_gnt(1'b0, g, t);
        check("single_gnt", 32'(g), 32'h1);
        check("single_cs_busy", 32'({cs_a, busy_a}), 32'h1);
        req_a = 2'b00;
        @(negedge clk);
        check("single_gnt_pulse", 32'(gnt_a), 32'h0);
        wait_done(1'b0, dn);
        check("single_done", 32'(dn), 32'h1);
`ifdef SPI_MASTER_MISO_EN
        check("miso_rx", 32'(rx_a), 32'h5A);
`endif
        @(negedge clk);
        check("single_done_pulse", 32'(done_a), 32'h0);
        check("single_cs_low", 32'(last_low_a), 32'd40);
        check("single_edges", 32'(last_edges_a), 32'd10);
        pop_byte(1'b0, b);
        check("single_byte", 32'(b), 32'hA5);

        // Fresh pointer, both requesting continuously: 0,1,0.
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        req_a = 2'b11;
        txd_a = {8'hC3, 8'h3C};
        for (int k = 0; k < 3; k++) begin
            wait_gnt(1'b0, g, t);
            check("both_gnt", 32'(g), 32'(exp_seq[k]));
            if (k > 0) check("both_spacing", 32'(t - tprev), 32'd45);
            tprev = t;
            if (k == 2) req_a = 2'b00;
            wait_done(1'b0, dn);
            check("both_done", 32'(dn), 32'(exp_seq[k]));
        end
        @(negedge clk);
        check("both_cs_gap", 32'(last_high_a >= 4), 32'h1);
        pop_byte(1'b0, b); check("both_byte0", 32'(b), 32'h3C);
        pop_byte(1'b0, b); check("both_byte1", 32'(b), 32'hC3);
        pop_byte(1'b0, b); check("both_byte2", 32'(b), 32'h3C);

        // Pointer rotation.
        frame_a(2'b10, 16'h1100, 2'b10, 8'h11, "rot_r1");
        frame_a(2'b01, 16'h0022, 2'b01, 8'h22, "rot_r0");
        frame_a(2'b11, 16'h4433, 2'b10, 8'h44, "rot_both");

        // Reset during the 4th data bit.
        req_a = 2'b01;
        txd_a = 16'h0077;
        wait_gnt(1'b0, g, t);
        check("mid_gnt", 32'(g), 32'h1);
        req_a = 2'b00;
        repeat (17) @(negedge clk);
        check("mid_pre_cs", 32'(cs_a), 32'h0);
        rst_a = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", 32'({cs_a, sclk_a, mosi_a, busy_a, gnt_a, done_a}), 32'h80);
        rst_a = 1'b0;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (done_a != 2'b00) cnt++;
        end
        check("mid_no_done", 32'(cnt), 32'h0);
        check("mid_no_byte", 32'(bytes_a.size()), 32'h0);
        frame_a(2'b10, 16'h8100, 2'b10, 8'h81, "mid_after");

        // Divider of 1 on instance B.
        check("reset_b", 32'({cs_b, sclk_b, mosi_b, busy_b, gnt_b, done_b}), 32'h80);
        rst_b = 1'b0;
        req_b = 2'b01;
        txd_b = 16'h00FF;
        wait_gnt(1'b1, g, t);
        check("div1_gnt0", 32'(g), 32'h1);
        req_b = 2'b00;
        cnt  = 0;
        prev = sclk_b;
        repeat (19) begin
            @(negedge clk);
            if (sclk_b != prev) cnt++;
            prev = sclk_b;
        end
        check("div1_toggles", 32'(cnt), 32'd19);
        wait_done(1'b1, dn);
        check("div1_done0", 32'(dn), 32'h1);
        @(negedge clk);
        check("div1_cs_low", 32'(last_low_b), 32'd20);
        pop_byte(1'b1, b);
        check("div1_byte0", 32'(b), 32'hFF);
        req_b = 2'b01;
        txd_b = 16'h0000;
        wait_gnt(1'b1, g, t);
        check("div1_gnt1", 32'(g), 32'h1);
        req_b = 2'b00;
        wait_done(1'b1, dn);
        check("div1_done1", 32'(dn), 32'h1);
`ifdef SPI_MASTER_MISO_EN
        check("div1_rx", 32'(rx_b), 32'h0);
`endif
        @(negedge clk);
        pop_byte(1'b1, b);
        check("div1_byte1", 32'(b), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spi_master_arb.md
Name: spi_master_arb

Overview:
- Round-robin arbitrated SPI master sharing one write-only SPI link (`sclk`/`mosi`/`cs`) between NUM_REQ on-chip requesters.
- Frames each byte to match the team's existing receive-only SPI slave, which samples `mosi` on the falling edge of `sclk` and uses active-low chip select.
- Frame sequence: 1 lead `sclk` period, 8 data periods (MSB first), 1 trail period.
- Sits between the system-clock logic and the SPI pins, generating `sclk` from `clk`.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- DATA_W, 8, bits per frame; fixed at 8 to match the slave.
- CLK_DIV, 4, `clk` cycles per `sclk` half-period (≥1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request per requester; held high until that requester's `gnt` pulse.
- tx_data  in  NUM_REQ*DATA_W  byte per requester; requester i uses slice [i*8 +: 8].
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse; `tx_data` of the granted requester is latched in that cycle.
- done  out  NUM_REQ  1-cycle pulse to the owning requester when its frame completes.
- busy  out  1  high from the grant cycle until the gap ends.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  SPI data.
- cs  out  1  chip select, active low.

Behaviour:
- Reset values: `sclk`=0, `mosi`=0, `cs`=1, `gnt`=0, `done`=0, `busy`=0; round-robin pointer = 0; state = IDLE.
- Reset mid-frame: outputs take reset values on the next `clk` edge; no `done` pulse; the frame is abandoned.
- All outputs are registered.
- FSM states: IDLE, LEAD, SHIFT, TRAIL, GAP.
- IDLE:
  - If any `req` is high, grant the first requester at or after the pointer, in modulo NUM_REQ order.
  - In that cycle: pulse `gnt`, latch the byte into an 8-bit shift register, record the owner, set pointer = owner+1 mod NUM_REQ, set `cs`=0, set `busy`=1, go to LEAD.
- Grant latency: `req` sampled high in IDLE produces `gnt` in the same cycle's registered output, i.e. visible 1 cycle later.
- `sclk` period structure:
  - Every period in LEAD/SHIFT/TRAIL is CLK_DIV `clk` cycles with `sclk` low, then CLK_DIV `clk` cycles with `sclk` high.
  - A divide counter runs 0..CLK_DIV-1 per half.
  - `mosi` updates only at the `sclk` rising edge, so it is stable across the following falling edge.
- LEAD: one period with `mosi`=0. This consumes the slave's idle-to-recv transition. Then go to SHIFT.
- SHIFT:
  - 8 periods; at each rising edge `mosi` = shift register MSB, then shift left.
  - A bit counter runs 0..7.
  - After the 8th falling edge, go to TRAIL.
- TRAIL: one period with `mosi`=0. At its final falling-edge cycle, pulse `done[owner]` and set `cs`=1. Go to GAP.
- GAP:
  - 2*CLK_DIV cycles with `cs`=1 and `sclk`=0.
  - Then `busy`=0 and return to IDLE.
  - Requests are not granted during GAP.
- Frame timing: `cs` is low for exactly 20*CLK_DIV `clk` cycles. Back-to-back frame spacing is 22*CLK_DIV+1 cycles.
- `req` changes while not IDLE are ignored. A requester dropping `req` before grant is not served. `tx_data` is don't-care outside the grant cycle.
- Simultaneous requests: only one grant per arbitration; fairness is by pointer rotation.

Optional Feature:
- Macro: SPI_MASTER_MISO_EN.
- Defined:
  - Adds input `miso` (1 bit) and output `rx_data` (8 bits, reset 0).
  - `miso` is sampled on each SHIFT falling-edge cycle and shifted in MSB first.
  - `rx_data` updates in the same cycle as `done`.
- Undefined: no `miso` or `rx_data` ports; behaviour otherwise identical.

Decomposition:
- Package `spi_pkg`:
  - State enum type `spi_mst_state_t`.
  - Constants SPI_FRAME_BITS=8, SPI_LEAD_PERIODS=1, SPI_TRAIL_PERIODS=1, SPI_GAP_PERIODS=1.
- Sub-module `rr_arbiter`: parameterized by NUM_REQ; inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and an encoded index. Purely combinational; the pointer register stays in `spi_master_arb`.

Test Plan:
- Single frame: CLK_DIV=2, `req[0]`=1, `tx_data[7:0]`=8'hA5 → `gnt`=2'b01 for 1 cycle; `cs` low for 40 cycles; 10 falling edges; the slave model captures 8'hA5 and asserts `done`; `done`=2'b01 pulses once.
- Simultaneous requests: `req`=2'b11 held, bytes 8'h3C (req0) and 8'hC3 (req1) → grants in order req0, req1, req0; the slave sees 3C, C3, 3C; `cs` is high for ≥4 cycles between frames.
- Pointer rotation: after serving req1, raise only `req[0]` → it is granted next; then raise `req[1]` and `req[0]` together → req1 is granted.
- Reset mid-frame: assert `rst` during the 4th SHIFT bit → the next cycle shows `cs`=1, `sclk`=0, `mosi`=0, `busy`=0; no `done` pulse; the next `req[1]` frame (8'h81) is received intact.
- Boundary divider: CLK_DIV=1, data 8'hFF then 8'h00 → `sclk` toggles every cycle; the slave captures FF then 00.
- SPI_MASTER_MISO_EN defined: `miso` driven with 8'h5A MSB first on the falling edges → `rx_data`=8'h5A in the `done` cycle.
